// File: rtl/wb_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg
// Definitions shared by the writeback arbiter and its source queues.
//   NSRC        : number of execution units feeding the writeback stage
//   SRC_*       : bit position of each execution unit in the src_* vectors
//   WB_DW/WB_TW : default result data width and destination tag width
//   wb_entry_t  : one queued result {tag, data} at the default widths
// ----------------------------------------------------------------------------
package wb_pkg;

   localparam int NSRC     = 4;
   localparam int SRC_ALU1 = 0;
   localparam int SRC_ALU2 = 1;
   localparam int SRC_MULT = 2;
   localparam int SRC_ADDR = 3;

   localparam int WB_DW = 16;
   localparam int WB_TW = 6;

   typedef struct packed {
      logic [WB_TW-1:0] tag;
      logic [WB_DW-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_src_fifo.sv
// ----------------------------------------------------------------------------
// wb_src_fifo
// Circular FIFO holding the pending results of one execution unit.
//   clk, rst : clock, asynchronous active-low reset
//   flush    : synchronous clear of pointers and count
//   push,din : write din at the write pointer (caller guarantees not full)
//   pop      : advance the read pointer (caller guarantees not empty)
//   dout     : current head entry
//   count    : number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module wb_src_fifo #(
   parameter  int W     = 22,
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  dout,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         // Simultaneous push and pop leaves the count unchanged.
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset: an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/wb_arbiter.sv
// ----------------------------------------------------------------------------
// wb_arbiter
// Writeback stage: queues results from alu1, alu2, mult and addr and drains
// them onto two register-file write ports with a rotating-priority pick.
//   clk, rst           : clock, asynchronous active-low reset
//   src_vld/tag/data   : per-source result (source i at [i*W +: W])
//   src_rdy            : per-source queue has room this cycle
//   flush              : squash everything queued and outgoing
//   wr0_*, wr1_*       : registered write ports (en, tag, data)
//   ovf_err            : sticky, a result arrived while its queue was full
//
// Handshake: a source result transfers at a rising edge where src_vld[i] and
// src_rdy[i] are both 1. src_rdy depends only on the queue count, so a pop in
// the same cycle does not open a slot. A valid with ready low is dropped and
// flagged in ovf_err. The write ports have no back-pressure: wrN_en is a
// single-cycle strobe.
// ----------------------------------------------------------------------------
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int DW    = WB_DW,
   parameter int TW    = WB_TW,
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NSRC-1:0]    src_vld,
   input  logic [NSRC*TW-1:0] src_tag,
   input  logic [NSRC*DW-1:0] src_data,
   output logic [NSRC-1:0]    src_rdy,
   input  logic               flush,
   output logic               wr0_en,
   output logic [TW-1:0]      wr0_tag,
   output logic [DW-1:0]      wr0_data,
   output logic               wr1_en,
   output logic [TW-1:0]      wr1_tag,
   output logic [DW-1:0]      wr1_data,
   output logic               ovf_err
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(NSRC);

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
   } entry_t;

   logic [CW-1:0]   cnt  [NSRC];
   entry_t          head [NSRC];
   logic [NSRC-1:0] push;
   logic [NSRC-1:0] pop;
   logic [NSRC-1:0] nonempty;

   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   idx;
   logic [PW-1:0]   g0_idx;
   logic [PW-1:0]   g1_idx;
   logic [PW-1:0]   last_idx;
   logic            g0_vld;
   logic            g1_vld;

   for (genvar i = 0; i < NSRC; i++) begin : g_src
      entry_t din;
      assign din = '{tag: src_tag[i*TW +: TW], data: src_data[i*DW +: DW]};

      wb_src_fifo #(
         .W     ($bits(entry_t)),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .flush (flush),
         .push  (push[i]),
         .din   (din),
         .pop   (pop[i]),
         .dout  (head[i]),
         .count (cnt[i])
      );

      assign src_rdy[i]  = (cnt[i] < CW'(DEPTH));
      assign nonempty[i] = (cnt[i] != '0);
   end

   // Flush discards same-cycle arrivals.
   assign push = src_vld & src_rdy & {NSRC{~flush}};

   // Rotating scan from rr_ptr: first non-empty queue to port 0, second to
   // port 1.
   always_comb begin
      idx    = '0;
      g0_vld = 1'b0;
      g1_vld = 1'b0;
      g0_idx = '0;
      g1_idx = '0;
      for (int k = 0; k < NSRC; k++) begin
         idx = rr_ptr + PW'(k);
         if (nonempty[idx]) begin
            if (!g0_vld) begin
               g0_vld = 1'b1;
               g0_idx = idx;
            end else if (!g1_vld) begin
               g1_vld = 1'b1;
               g1_idx = idx;
            end
         end
      end
      last_idx = g1_vld ? g1_idx : g0_idx;
      pop      = '0;
      if (!flush) begin
         if (g0_vld) pop[g0_idx] = 1'b1;
         if (g1_vld) pop[g1_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr   <= '0;
         wr0_en   <= 1'b0;
         wr0_tag  <= '0;
         wr0_data <= '0;
         wr1_en   <= 1'b0;
         wr1_tag  <= '0;
         wr1_data <= '0;
         ovf_err  <= 1'b0;
      end else if (flush) begin
         rr_ptr <= '0;
         wr0_en <= 1'b0;
         wr1_en <= 1'b0;
      end else begin
         if (|(src_vld & ~src_rdy)) ovf_err <= 1'b1;
         wr0_en <= g0_vld;
         wr1_en <= g1_vld;
         // Ports without a grant keep their last tag/data.
         if (g0_vld) begin
            wr0_tag  <= head[g0_idx].tag;
            wr0_data <= head[g0_idx].data;
         end
         if (g1_vld) begin
            wr1_tag  <= head[g1_idx].tag;
            wr1_data <= head[g1_idx].data;
         end
         // Priority restarts just past the last source served.
         if (g0_vld) rr_ptr <= last_idx + PW'(1);
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
   import wb_pkg::*;

   localparam int DW    = 16;
   localparam int TW    = 6;
   localparam int DEPTH = 2;
   localparam int EW    = 2 * (1 + TW + DW) + 1;

   // ---------------- clock / reset ----------------
   logic               clk;
   logic               rst;
   logic [NSRC-1:0]    src_vld;
   logic [NSRC*TW-1:0] src_tag;
   logic [NSRC*DW-1:0] src_data;
   logic [NSRC-1:0]    src_rdy;
   logic               flush;
   logic               wr0_en;
   logic [TW-1:0]      wr0_tag;
   logic [DW-1:0]      wr0_data;
   logic               wr1_en;
   logic [TW-1:0]      wr1_tag;
   logic [DW-1:0]      wr1_data;
   logic               ovf_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wb_arbiter #(.DW(DW), .TW(TW), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .src_vld  (src_vld),
      .src_tag  (src_tag),
      .src_data (src_data),
      .src_rdy  (src_rdy),
      .flush    (flush),
      .wr0_en   (wr0_en),
      .wr0_tag  (wr0_tag),
      .wr0_data (wr0_data),
      .wr1_en   (wr1_en),
      .wr1_tag  (wr1_tag),
      .wr1_data (wr1_data),
      .ovf_err  (ovf_err)
   );

   // ---------------- scoreboard / reference model ----------------
   int n_tests = 0;
   int n_fail  = 0;

   logic [EW-1:0]      exp_q [$];
   logic [TW+DW-1:0]   mq [NSRC][$];
   int                 m_rr;
   logic               m_ovf;
   logic               m_en0, m_en1;
   logic [TW-1:0]      m_tag0, m_tag1;
   logic [DW-1:0]      m_data0, m_data1;
   int                 gcnt [NSRC];
   logic [TW-1:0]      mult_seen [$];

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NSRC; i++) mq[i].delete();
      exp_q.delete();
      m_rr = 0; m_ovf = 1'b0;
      m_en0 = 1'b0; m_tag0 = '0; m_data0 = '0;
      m_en1 = 1'b0; m_tag1 = '0; m_data1 = '0;
   endtask

   // Predict the port/flag state after the coming edge and queue it.
   task automatic model_edge(input logic [NSRC-1:0] v, input logic [NSRC*TW-1:0] t,
                             input logic [NSRC*DW-1:0] d, input logic fl);
      logic [NSRC-1:0]  rdy;
      logic [TW+DW-1:0] e;
      int ng, last, s;
      for (int i = 0; i < NSRC; i++) rdy[i] = (mq[i].size() < DEPTH);
      if (fl) begin
         for (int i = 0; i < NSRC; i++) mq[i].delete();
         m_rr = 0; m_en0 = 1'b0; m_en1 = 1'b0;
      end else begin
         ng = 0; last = 0;
         m_en0 = 1'b0; m_en1 = 1'b0;
         for (int k = 0; k < NSRC; k++) begin
            s = (m_rr + k) % NSRC;
            if (ng < 2 && mq[s].size() > 0) begin
               e = mq[s].pop_front();
               if (ng == 0) begin
                  m_en0 = 1'b1; m_tag0 = e[TW+DW-1:DW]; m_data0 = e[DW-1:0];
               end else begin
                  m_en1 = 1'b1; m_tag1 = e[TW+DW-1:DW]; m_data1 = e[DW-1:0];
               end
               last = s; ng++;
            end
         end
         if (ng > 0) m_rr = (last + 1) % NSRC;
         for (int i = 0; i < NSRC; i++) begin
            if (v[i]) begin
               if (rdy[i]) mq[i].push_back({t[i*TW +: TW], d[i*DW +: DW]});
               else        m_ovf = 1'b1;
            end
         end
      end
      exp_q.push_back({m_ovf, m_en0, m_tag0, m_data0, m_en1, m_tag1, m_data1});
   endtask

   // ---------------- driver ----------------
   task automatic cycle(input logic [NSRC-1:0] v, input logic [NSRC*TW-1:0] t,
                        input logic [NSRC*DW-1:0] d, input logic fl);
      logic [NSRC-1:0] exp_rdy;
      logic [EW-1:0]   exp;
      src_vld = v; src_tag = t; src_data = d; flush = fl;
      for (int i = 0; i < NSRC; i++) exp_rdy[i] = (mq[i].size() < DEPTH);
      check("src_rdy", 64'(src_rdy), 64'(exp_rdy));
      model_edge(v, t, d, fl);
      @(posedge clk);
      #1;
      src_vld = '0; flush = 1'b0;
      exp = exp_q.pop_front();
      check("wr_ports", 64'({ovf_err, wr0_en, wr0_tag, wr0_data, wr1_en, wr1_tag, wr1_data}),
            64'(exp));
      if (wr0_en) gcnt[wr0_tag[5:4]]++;
      if (wr1_en) gcnt[wr1_tag[5:4]]++;
      if (wr0_en && wr0_tag[5:4] == 2'(SRC_MULT)) mult_seen.push_back(wr0_tag);
      if (wr1_en && wr1_tag[5:4] == 2'(SRC_MULT)) mult_seen.push_back(wr1_tag);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle('0, '0, '0, 1'b0);
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, 64'({wr0_en, wr0_tag, wr0_data, wr1_en, wr1_tag, wr1_data, ovf_err}), 64'(0));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [NSRC*TW-1:0] t;
      logic [NSRC*DW-1:0] d;
      logic [DW-1:0]      pat_a, pat_b;
      logic [3:0]         seq;

      rst = 1'b0; src_vld = '0; src_tag = '0; src_data = '0; flush = 1'b0;
      model_reset();
      for (int i = 0; i < NSRC; i++) gcnt[i] = 0;
      @(posedge clk); @(posedge clk); #1;
      check_reset_outputs("reset_outputs");
      #3 rst = 1'b1;
      #1;
      check("reset_rdy", 64'(src_rdy), 64'(4'b1111));

      // Single result from alu1.
      pat_a = 16'haaaa; pat_b = 16'h5555;
      t = '0; d = '0;
      t[SRC_ALU1*TW +: TW] = 6'd5;
      d[SRC_ALU1*DW +: DW] = pat_a & pat_b;
      cycle(4'b0001, t, d, 1'b0);
      check("single_not_early", 64'(wr0_en), 64'(0));
      idle(1);
      check("single_port0", 64'({wr0_en, wr0_tag, wr0_data}), 64'({1'b1, 6'd5, 16'h0000}));
      check("single_port1_idle", 64'(wr1_en), 64'(0));

      // Flush to put rr_ptr back at 0, then four-way collision.
      cycle('0, '0, '0, 1'b1);
      t = {6'd4, 6'd3, 6'd2, 6'd1};
      d = {16'd400, 16'd180, 16'd200, 16'd100};
      cycle(4'b1111, t, d, 1'b0);
      idle(1);
      check("collide_first", 64'({wr0_en, wr0_tag, wr1_en, wr1_tag}),
            64'({1'b1, 6'd1, 1'b1, 6'd2}));
      idle(1);
      check("collide_second", 64'({wr0_en, wr0_tag, wr0_data, wr1_en, wr1_tag}),
            64'({1'b1, 6'd3, 16'd180, 1'b1, 6'd4}));
      idle(1);
      check("collide_drained", 64'({wr0_en, wr1_en}), 64'(0));
      // rr_ptr back at 0: alu2 must win port 0 over mult.
      t = '0; d = '0;
      t[SRC_ALU2*TW +: TW] = 6'd9;  d[SRC_ALU2*DW +: DW] = 16'h1234;
      t[SRC_MULT*TW +: TW] = 6'd10; d[SRC_MULT*DW +: DW] = 16'h5678;
      cycle(4'b0110, t, d, 1'b0);
      idle(1);
      check("rr_back_to_0", 64'({wr0_tag, wr1_tag}), 64'({6'd9, 6'd10}));

      // Flush with alu2 and addr entries pending.
      t = '0; d = '0;
      t[SRC_ALU2*TW +: TW] = 6'd11; d[SRC_ALU2*DW +: DW] = 16'h00b0;
      t[SRC_ADDR*TW +: TW] = 6'd12; d[SRC_ADDR*DW +: DW] = 16'h00c0;
      cycle(4'b1010, t, d, 1'b0);
      t = '0; d = '0;
      t[SRC_ALU1*TW +: TW] = 6'd13;
      cycle(4'b0001, t, d, 1'b1);
      check("flush_en", 64'({wr0_en, wr1_en}), 64'(0));
      check("flush_rdy", 64'(src_rdy), 64'(4'b1111));
      check("flush_no_ovf", 64'(ovf_err), 64'(0));
      idle(2);
      check("flush_nothing_written", 64'({wr0_en, wr1_en}), 64'(0));

      // Back-pressure on mult while alu1/alu2 compete.
      mult_seen.delete();
      for (int c = 1; c <= 3; c++) begin
         t = '0; d = '0;
         t[SRC_ALU1*TW +: TW] = {2'(SRC_ALU1), 4'(c)};
         t[SRC_ALU2*TW +: TW] = {2'(SRC_ALU2), 4'(c)};
         t[SRC_MULT*TW +: TW] = {2'(SRC_MULT), 4'(c)};
         d[SRC_MULT*DW +: DW] = 16'(c * 16'h0101);
         if (c == 3) check("bp_mult_not_ready", 64'(src_rdy[SRC_MULT]), 64'(0));
         cycle(4'b0111, t, d, 1'b0);
      end
      check("bp_ovf_set", 64'(ovf_err), 64'(1));
      idle(4);
      check("bp_mult_count", 64'(mult_seen.size()), 64'(2));
      if (mult_seen.size() == 2) begin
         check("bp_mult_first", 64'(mult_seen[0]), 64'(6'h21));
         check("bp_mult_second", 64'(mult_seen[1]), 64'(6'h22));
      end

      // Reset in the middle of traffic.
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < NSRC; i++) begin
            t[i*TW +: TW] = {2'(i), 4'(c + 4)};
            d[i*DW +: DW] = $urandom_range(0, 16'hffff);
         end
         cycle(4'b1111, t, d, 1'b0);
      end
      src_vld = 4'b1111;
      #2 rst = 1'b0;
      #1;
      check_reset_outputs("midreset_immediate");
      model_reset();
      @(posedge clk); #1;
      src_vld = '0;
      #2 rst = 1'b1;
      #1;
      check("midreset_rdy", 64'(src_rdy), 64'(4'b1111));
      check_reset_outputs("midreset_outputs");

      // Fairness and FIFO order across pointer wrap.
      for (int i = 0; i < NSRC; i++) gcnt[i] = 0;
      seq = 4'd0;
      for (int c = 0; c < 21; c++) begin
         for (int i = 0; i < NSRC; i++) begin
            t[i*TW +: TW] = {2'(i), seq};
            d[i*DW +: DW] = $urandom_range(0, 16'hffff);
         end
         seq = seq + 4'd1;
         cycle(4'b1111, t, d, 1'b0);
      end
      for (int i = 0; i < NSRC; i++)
         check($sformatf("fair_src%0d", i), 64'(gcnt[i] >= 9 && gcnt[i] <= 11), 64'(1));
      idle(4);
      check("final_drained", 64'({wr0_en, wr1_en}), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly downstream of the execution block.
- Collects results from the four execution units (alu1, alu2, mult, addr) into small per-source queues.
- Arbitrates them onto two register-file write ports and broadcasts completion tags.
- Back-pressures each execution unit with a per-source ready signal.

Parameters:
- DW, 16: result data width.
- TW, 6: physical destination tag width.
- DEPTH, 2: entries per source queue (power of two, ≥2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- src_vld  in  4  result valid per source: bit0 alu1, bit1 alu2, bit2 mult, bit3 addr.
- src_tag  in  4*TW  destination tag per source; source i occupies [i*TW +: TW].
- src_data  in  4*DW  result per source; source i occupies [i*DW +: DW].
- src_rdy  out  4  source queue can accept this cycle.
- flush  in  1  synchronous squash of all queued and outgoing results.
- wr0_en  out  1  write port 0 valid.
- wr0_tag  out  TW  write port 0 tag.
- wr0_data  out  DW  write port 0 data.
- wr1_en  out  1  write port 1 valid.
- wr1_tag  out  TW  write port 1 tag.
- wr1_data  out  DW  write port 1 data.
- ovf_err  out  1  sticky: a valid was presented while its source was not ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - All queues empty, rr_ptr=0.
  - wr0_en, wr1_en, ovf_err = 0; wr*_tag, wr*_data = 0.
  - src_rdy = 4'b1111 once rst releases.
- Queues: one circular FIFO per source with read pointer, write pointer and count (0..DEPTH).
  - src_rdy[i] = (count_i < DEPTH), combinational from count only. A same-cycle dequeue does not raise ready.
- Enqueue: at an edge with src_vld[i]=1 and src_rdy[i]=1, {tag, data} is written at the write pointer, which then increments mod DEPTH.
  - src_vld[i]=1 with src_rdy[i]=0: the result is dropped and ovf_err is set to 1. ovf_err clears only on reset.
- Arbitration (combinational on queue heads, each cycle):
  - Scan sources starting at rr_ptr in the order rr_ptr, rr_ptr+1, … mod 4.
  - The first non-empty source is granted to port 0; the second non-empty source is granted to port 1.
  - At most one grant per source per cycle.
- Dequeue: granted heads are popped at the edge. Registered outputs then load:
  - wrN_en=1, wrN_tag and wrN_data from the granted head.
  - A port with no grant loads wrN_en=0; its tag and data hold their previous values.
- Latency: a result captured at edge E appears on a write port at edge E+1 at the earliest, i.e. 2 cycles from src_vld to wr*_en.
- rr_ptr update:
  - If any grant: rr_ptr = (index of the last granted source + 1) mod 4.
  - Otherwise rr_ptr holds.
  - Guarantees each non-empty source a grant within 2 cycles.
- Simultaneous enqueue and dequeue on the same queue: both occur and the count is unchanged. A queue at count=DEPTH never enqueues.
- Wrap-around: pointers wrap at DEPTH; FIFO order is preserved per source.
- Ordering: there is no ordering guarantee across sources.
- flush=1 at an edge:
  - All counts and pointers go to 0; wr0_en and wr1_en go to 0.
  - Same-cycle inputs are discarded without setting ovf_err.
  - rr_ptr resets to 0.
  - flush has priority over enqueue and grant.
- Reset mid-operation: all queued data is lost; outputs follow the reset values immediately.

Decomposition:
- Shared package wb_pkg holds:
  - source index constants SRC_ALU1=0, SRC_ALU2=1, SRC_MULT=2, SRC_ADDR=3;
  - NSRC=4;
  - the result entry struct {tag, data}.
- One sub-module, wb_src_fifo (DEPTH entries, push/pop/count/flush), instantiated four times.
- Round-robin pick and output registers live in the top module.

Test Plan:
- Reset: hold rst=0 mid-traffic, release → wr0_en=wr1_en=0, src_rdy=4'b1111, ovf_err=0.
- Single result: alu1 valid, tag=5, data=16'h0000 (1010…&0101…) at edge E → wr0_en=1, wr0_tag=5, wr0_data=16'h0000 after edge E+1; wr1_en=0.
- Four-way collision: all four sources valid in one cycle (alu1 tag1, alu2 tag2, mult tag3 data=180, addr tag4), rr_ptr=0:
  - next cycle ports carry tags 1 and 2;
  - the cycle after carries tags 3 and 4;
  - rr_ptr returns to 0.
- Back-pressure: mult valid for 3 consecutive cycles while its head is never granted (alu1/alu2 saturating, rr_ptr forced) → src_rdy[2]=0 after 2 entries; 3rd valid sets ovf_err=1; queued values emerge in order.
- Flush: 2 entries queued in alu2 and addr, assert flush → next cycle wr*_en=0, all src_rdy=1, no queued tag is ever written.
- Fairness/wrap: continuous valids on all four sources for 20 cycles → each source granted 10 times ±1; per-source tags stay in FIFO order across pointer wrap.
